// File: rtl/irq_priority_ctrl_pkg.sv
// irq_priority_ctrl_pkg: shared types and sizes for the interrupt priority controller
package irq_priority_ctrl_pkg;
    localparam int NUM_SRC = 8;
    localparam int ID_W = 3;
    typedef enum logic [1:0] {IDLE, PRESENT, CLEAR} state_t;
endpackage

// File: rtl/irq_priority_ctrl_priority_enc8.sv
// priority_enc8: index of the highest set bit of an 8-bit vector plus an any-set flag
module priority_enc8
    import irq_priority_ctrl_pkg::*;
(
    input  logic [7:0]      vec,
    output logic [ID_W-1:0] id,
    output logic            any
);
    // scan upwards so the highest set bit is the last one written
    always_comb begin
        id = '0;
        for (int i = 0; i < 8; i++) id = vec[i] ? ID_W'(i) : id;
        any = |vec;
    end
endmodule

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: captures request edges and presents the highest unmasked pending source
module irq_priority_ctrl
    import irq_priority_ctrl_pkg::*;
#(
    parameter int NUM_SRC = irq_priority_ctrl_pkg::NUM_SRC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req_in,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               irq_ack,
    input  logic               lost_clr,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] lost
);
    state_t state, state_nx;
    logic [NUM_SRC-1:0] req_q, edges, eligible, clr;
    logic [ID_W-1:0] win_id;
    logic any;

    assign edges = req_in & ~req_q;
    assign eligible = pending & mask;

    priority_enc8 u_enc (.vec(eligible), .id(win_id), .any(any));

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // next state: present when something is eligible, hold until ack, one idle gap after
    always_comb
        state_nx = state == IDLE    ? (any ? PRESENT : IDLE) :
                   state == PRESENT ? (irq_ack ? CLEAR : PRESENT) : IDLE;

    // outputs: valid follows the state flop, ack only clears while presenting
    always_comb begin
        irq_valid = state == PRESENT;
        clr = (irq_valid && irq_ack) ? (NUM_SRC'(1) << irq_id) : '0;
    end

    // edge capture; a new edge beats a same-cycle clear, and a new lost event beats lost_clr
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            req_q <= '0;
            pending <= '0;
            lost <= '0;
        end else begin
            req_q <= req_in;
            pending <= (pending & ~clr) | edges;
            lost <= (lost & ~{NUM_SRC{lost_clr}}) | (edges & pending & ~clr);
        end

    // id is latched only when a presentation starts, so it stays stable while presenting
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) irq_id <= '0;
        else if (state == IDLE && any) irq_id <= win_id;
endmodule
